icu_sequencer: RTL and testbench
================================

ICU_SEQUENCER -- requirements
Module: icu_sequencer

Interface
REQ-001 SHALL have parameter RST_PC, default 7'h00, meaning the program counter value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port run, input, 1, high permits instruction fetch; low holds the sequencer in FETCH.
REQ-005 SHALL have port rom_addr, output, 7, combinational address to the 128x8 asynchronous-read program ROM.
REQ-006 SHALL have port rom_data, input, 8, ROM word: [7:4] opcode, [3:0] I/O/scratch address.
REQ-007 SHALL have port icu_rr, input, 1, MC14500B result register.
REQ-008 SHALL have port icu_op, output, 4, opcode presented to the ICU.
REQ-009 SHALL have port icu_addr, output, 4, operand address presented to the ICU/IO decode.
REQ-010 SHALL have port icu_strobe, output, 1, one-cycle pulse qualifying icu_op/icu_addr.
REQ-011 SHALL have ports flag0 and flagf, output, 1 each, one-cycle pulses on executed NOPO (0x0) and NOPF (0xF).
REQ-012 SHALL have port pc, output, 7, current program counter for debug.

Function
REQ-013 SHALL implement the states FETCH, EXEC and JTGT.
REQ-014 FETCH: rom_addr = pc; if run=1, latch rom_data into ir and go to EXEC; if run=0, stay in FETCH with no strobe.
REQ-015 EXEC: icu_op = ir[7:4], icu_addr = ir[3:0]; icu_strobe = 1 unless skip=1.
REQ-016 EXEC, non-skipped, opcodes other than C/D/E: pc <= pc+1; go to FETCH.
REQ-017 EXEC, SKZ (0xE), non-skipped: skip <= (icu_rr==0); pc <= pc+1.
REQ-018 EXEC, JMP (0xC), non-skipped: ret <= pc; go to JTGT.
REQ-019 JTGT: rom_addr = pc+1; pc <= rom_data[6:0]; rom_data[7] is ignored; no strobe; go to FETCH.
REQ-020 EXEC, RTN (0xD), non-skipped: pc <= ret; skip <= 1, so the JMP at ret, including its target byte, is skipped.
REQ-021 EXEC with skip=1: strobe, flag0 and flagf are suppressed and skip is cleared.
REQ-022 Skipped instruction advance: pc <= pc+2 for a skipped JMP, otherwise pc <= pc+1; a skipped SKZ/RTN does not alter skip/ret.
REQ-023 All pc arithmetic SHALL be modulo 128: 127+1 wraps to 0, 127+2 to 1, and a JTGT read at pc=127 uses address 0.
REQ-024 Throughput SHALL be 2 cycles per instruction and 3 cycles for an executed JMP.
REQ-025 A one-level return register SHALL be used; a nested JMP overwrites ret.
REQ-026 Outside EXEC, icu_strobe, flag0 and flagf SHALL be 0 and icu_op/icu_addr SHALL hold their last values.
REQ-027 run SHALL be sampled only in FETCH; deasserting run in EXEC/JTGT completes the instruction first.

Reset
REQ-028 On rst=1 at a clock edge: state=FETCH, pc=RST_PC, ret=0, skip=0, ir=0, icu_strobe=0, flag0=0, flagf=0, icu_op=0, icu_addr=0.
REQ-029 rst SHALL take priority over all transitions; a reset during EXEC or JTGT abandons the instruction with no strobe in the following cycle.

Verification
REQ-030 Reset then run=1 with ROM[0]=0x11, ROM[1]=0x83 -> strobe with op=1/addr=1 in cycle 2 and op=8/addr=3 in cycle 4; pc=2 after 4 cycles.
REQ-031 ROM[0]=0xE0, icu_rr=0, ROM[1]=0x85, ROM[2]=0x11 -> no strobe for 0x85, pc=2 at the third FETCH, strobe for 0x11.
REQ-032 ROM[5]=0xC0, ROM[6]=0x40, ROM[0x40]=0xD0 -> JMP strobe, pc=0x40, ret=5; RTN -> pc=5 with skip set; JMP skipped; next executed instruction is ROM[7].
REQ-033 pc=127 with ROM[127]=0x10 -> next fetch at 0; pc=127 with ROM[127]=0xC0, ROM[0]=0x12 -> jump to 0x12.
REQ-034 ROM[0]=0xF0, ROM[1]=0x00 -> flagf pulse in the first EXEC and flag0 in the second, each exactly one cycle.
REQ-035 Assert rst in JTGT, or hold run=0 for 5 cycles -> pc=RST_PC with no strobe, or the sequencer holds in FETCH with pc unchanged and no strobe.

Source files
------------

// File: rtl/icu_sequencer.sv
// Program sequencer for an MC14500B-style ICU: fetches 8-bit words from an
// asynchronous-read ROM and handles JMP/RTN/SKZ flow control around the ICU.
module icu_sequencer #(
   parameter logic [6:0] RST_PC = 7'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   output logic [6:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic       icu_rr,
   output logic [3:0] icu_op,
   output logic [3:0] icu_addr,
   output logic       icu_strobe,
   output logic       flag0,
   output logic       flagf,
   output logic [6:0] pc
);

   typedef enum logic [1:0] {FETCH, EXEC, JTGT} state_t;

   localparam logic [3:0] OP_NOPO = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RTN  = 4'hD;
   localparam logic [3:0] OP_SKZ  = 4'hE;
   localparam logic [3:0] OP_NOPF = 4'hF;

   state_t     state_q, state_d;
   logic [6:0] pc_q, pc_d;
   logic [6:0] ret_q, ret_d;
   logic       skip_q, skip_d;
   logic [7:0] ir_q, ir_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RST_PC;
         ret_q   <= 7'h00;
         skip_q  <= 1'b0;
         ir_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ret_q   <= ret_d;
         skip_q  <= skip_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ret_d      = ret_q;
      skip_d     = skip_q;
      ir_d       = ir_q;
      rom_addr   = pc_q;
      icu_strobe = 1'b0;
      case (state_q)
         FETCH: begin
            if (run) begin
               ir_d    = rom_data;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = FETCH;
            if (skip_q) begin
               // A skipped JMP must also step over its target byte.
               skip_d = 1'b0;
               pc_d   = pc_q + ((ir_q[7:4] == OP_JMP) ? 7'd2 : 7'd1);
            end else begin
               icu_strobe = 1'b1;
               case (ir_q[7:4])
                  OP_JMP: begin
                     ret_d   = pc_q;
                     state_d = JTGT;
                  end
                  OP_RTN: begin
                     // Return lands on the JMP itself; skip it and its target.
                     pc_d   = ret_q;
                     skip_d = 1'b1;
                  end
                  OP_SKZ: begin
                     skip_d = ~icu_rr;
                     pc_d   = pc_q + 7'd1;
                  end
                  default: pc_d = pc_q + 7'd1;
               endcase
            end
         end
         JTGT: begin
            rom_addr = pc_q + 7'd1;
            pc_d     = rom_data[6:0];
            state_d  = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // ir only changes on a fetch, so op/addr naturally hold outside EXEC.
   assign icu_op   = ir_q[7:4];
   assign icu_addr = ir_q[3:0];
   assign flag0    = icu_strobe && (ir_q[7:4] == OP_NOPO);
   assign flagf    = icu_strobe && (ir_q[7:4] == OP_NOPF);
   assign pc       = pc_q;

endmodule

// File: tb/tb_icu_sequencer.sv
// Scoreboard bench for icu_sequencer: directed ROM programs push expected
// strobes; a negedge monitor pops and compares every strobe it sees.
module tb_icu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic [6:0] rom_addr;
   logic [7:0] rom_data;
   logic       icu_rr = 1'b0;
   logic [3:0] icu_op;
   logic [3:0] icu_addr;
   logic       icu_strobe;
   logic       flag0;
   logic       flagf;
   logic [6:0] pc;

   logic [7:0] rom [128];
   logic [16:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   assign rom_data = rom[rom_addr];

   icu_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
      .icu_rr(icu_rr), .icu_op(icu_op), .icu_addr(icu_addr), .icu_strobe(icu_strobe),
      .flag0(flag0), .flagf(flagf), .pc(pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Expected strobe record: {op, addr, pc, flag0, flagf}
   task automatic push(input logic [3:0] op, input logic [3:0] addr, input logic [6:0] p,
                       input logic f0, input logic ff);
      exp_q.push_back({op, addr, p, f0, ff});
   endtask

   always @(negedge clk) begin
      logic [16:0] got;
      logic [16:0] req;
      got = {icu_op, icu_addr, pc, flag0, flagf};
      if (icu_strobe) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe actual=%0h required=none", got);
         end else begin
            req = exp_q.pop_front();
            check("strobe{op,addr,pc,f0,ff}", int'(got), int'(req));
            $display("strobe op=%0h addr=%0h pc=%0h f0=%0b ff=%0b", icu_op, icu_addr, pc, flag0, flagf);
         end
      end else if (flag0 || flagf) begin
         checks++;
         errors++;
         $display("FAIL flag_without_strobe actual=%0b%0b required=00", flag0, flagf);
      end
   end

   task automatic rom_clear();
      for (int i = 0; i < 128; i++) rom[i] = 8'h80;
   endtask

   task automatic do_reset();
      run = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("reset_pc", int'(pc), 0);
      check("reset_strobe", int'(icu_strobe), 0);
      check("reset_op_addr", int'({icu_op, icu_addr}), 0);
   endtask

   // Run for n clock edges, then drop run and idle; pc must settle at exp_pc.
   task automatic run_prog(input string name, input int n, input int exp_pc);
      run = 1'b1;
      repeat (n) @(posedge clk);
      #1 run = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check({name, "_pc"}, int'(pc), exp_pc);
      check({name, "_drain"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      // Two plain instructions.
      rom_clear(); rom[0] = 8'h11; rom[1] = 8'h83;
      do_reset();
      push(4'h1, 4'h1, 7'd0, 0, 0);
      push(4'h8, 4'h3, 7'd1, 0, 0);
      run = 1'b1;
      repeat (4) @(posedge clk);
      #1 run = 1'b0;
      check("basic_pc_after_4", int'(pc), 2);
      repeat (6) @(posedge clk);
      #1 check("hold_pc", int'(pc), 2);
      check("hold_drain", exp_q.size(), 0);

      // SKZ with rr=0 skips the next instruction.
      rom_clear(); rom[0] = 8'hE0; rom[1] = 8'h85; rom[2] = 8'h11;
      icu_rr = 1'b0;
      do_reset();
      push(4'hE, 4'h0, 7'd0, 0, 0);
      push(4'h1, 4'h1, 7'd2, 0, 0);
      run_prog("skz0", 6, 3);

      // SKZ with rr=1 does not skip.
      icu_rr = 1'b1;
      do_reset();
      push(4'hE, 4'h0, 7'd0, 0, 0);
      push(4'h8, 4'h5, 7'd1, 0, 0);
      push(4'h1, 4'h1, 7'd2, 0, 0);
      run_prog("skz1", 6, 3);
      icu_rr = 1'b0;

      // Nested JMP then RTN: returns onto JMP at 5, skips it, resumes at 7.
      rom_clear(); rom[0] = 8'hC0; rom[1] = 8'h05; rom[5] = 8'hC0; rom[6] = 8'h40;
      rom[7'h40] = 8'hD0; rom[7] = 8'h27;
      do_reset();
      push(4'hC, 4'h0, 7'd0, 0, 0);
      push(4'hC, 4'h0, 7'd5, 0, 0);
      push(4'hD, 4'h0, 7'h40, 0, 0);
      push(4'h2, 4'h7, 7'd7, 0, 0);
      run_prog("jmp_rtn", 12, 8);

      // Increment wraps 127 -> 0.
      rom_clear(); rom[0] = 8'hC0; rom[1] = 8'h7F; rom[127] = 8'h10;
      do_reset();
      push(4'hC, 4'h0, 7'd0, 0, 0);
      push(4'h1, 4'h0, 7'd127, 0, 0);
      run_prog("wrap_inc", 5, 0);

      // JMP at 127 reads its target from address 0; target bit 7 ignored.
      rom_clear(); rom[0] = 8'h12; rom[1] = 8'hC0; rom[2] = 8'hFF; rom[127] = 8'hC0;
      rom[7'h12] = 8'h35;
      do_reset();
      push(4'h1, 4'h2, 7'd0, 0, 0);
      push(4'hC, 4'h0, 7'd1, 0, 0);
      push(4'hC, 4'h0, 7'd127, 0, 0);
      push(4'h3, 4'h5, 7'h12, 0, 0);
      run_prog("wrap_jtgt", 10, 8'h13);

      // Skipped JMP at 127 advances by two, wrapping to 1.
      rom_clear(); rom[0] = 8'hC0; rom[1] = 8'h7E; rom[126] = 8'hE0; rom[127] = 8'hC0;
      do_reset();
      push(4'hC, 4'h0, 7'd0, 0, 0);
      push(4'hE, 4'h0, 7'd126, 0, 0);
      push(4'h7, 4'hE, 7'd1, 0, 0);
      run_prog("wrap_skip", 9, 2);

      // NOPF then NOPO flag pulses.
      rom_clear(); rom[0] = 8'hF0; rom[1] = 8'h00;
      do_reset();
      push(4'hF, 4'h0, 7'd0, 0, 1);
      push(4'h0, 4'h0, 7'd1, 1, 0);
      run_prog("flags", 4, 2);

      // run dropped during EXEC: instruction still completes.
      rom_clear(); rom[0] = 8'h11; rom[1] = 8'h83;
      do_reset();
      push(4'h1, 4'h1, 7'd0, 0, 0);
      run_prog("run_drop_exec", 1, 1);

      // Reset asserted while in JTGT abandons the jump.
      rom_clear(); rom[0] = 8'hC0; rom[1] = 8'h33;
      do_reset();
      push(4'hC, 4'h0, 7'd0, 0, 0);
      run = 1'b1;
      repeat (2) @(posedge clk);
      #1 begin rst = 1'b1; run = 1'b0; end
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst_jtgt_pc", int'(pc), 0);
      check("rst_jtgt_strobe", int'(icu_strobe), 0);
      repeat (5) @(posedge clk);
      #1 check("rst_jtgt_hold_pc", int'(pc), 0);
      check("rst_jtgt_drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
